// File: rtl/clock_report_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_report_pkg
// Description : Shared ASCII constants, frame lengths and FSM state encoding
//               for the clock time reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_report_pkg;

  // ASCII characters used in the time frame
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Frame lengths in bytes, with and without the centiseconds field
  localparam int FRAME_LEN_MSEC    = 13;
  localparam int FRAME_LEN_NO_MSEC = 10;

  // Byte index width: enough to count up to 13
  localparam int IDX_W = 4;

  // ST_LOAD gives one cycle between request acceptance and the first SEND
  // evaluation, so the first strobe lands two cycles after the request edge.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  // Clamp a 0..127 value to at most 99 so it fits two decimal digits
  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_bin2ascii.sv
`default_nettype none
// ============================================================================
// Module      : clock_bin2ascii
// Description : Combinational binary (0..127) to two ASCII decimal digits,
//               saturating at "99".
// Revision    : 1.0 - initial release
// ============================================================================
module clock_bin2ascii
  import clock_report_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [6:0] sat;
  logic [3:0] tens_dig;
  logic [3:0] ones_dig;

  // Saturate first so both digits stay within 0..9
  assign sat      = sat99(bin);
  assign tens_dig = 4'(sat / 7'd10);
  assign ones_dig = 4'(sat % 7'd10);

  assign tens = ASCII_ZERO + {4'd0, tens_dig};
  assign ones = ASCII_ZERO + {4'd0, ones_dig};

endmodule
`default_nettype wire

// File: rtl/clock_time_reporter.sv
`default_nettype none
// ============================================================================
// Module      : clock_time_reporter
// Description : On request, snapshots hour/min/sec/centisec and streams the
//               ASCII frame "HH:MM:SS[.CC]\r\n" to a UART transmitter using
//               a start/busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_time_reporter
  import clock_report_pkg::*;
#(
  parameter int SEND_MSEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = (SEND_MSEC != 0) ?
                                          IDX_W'(FRAME_LEN_MSEC - 1) :
                                          IDX_W'(FRAME_LEN_NO_MSEC - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [4:0]       snap_hour;
  logic [5:0]       snap_min;
  logic [5:0]       snap_sec;
  logic [6:0]       snap_msec;

  logic [7:0] hour_t, hour_o;
  logic [7:0] min_t,  min_o;
  logic [7:0] sec_t,  sec_o;
  logic [7:0] msec_t, msec_o;
  logic [7:0] cur_byte;

  clock_bin2ascii u_hour (.bin({2'b00, snap_hour}), .tens(hour_t), .ones(hour_o));
  clock_bin2ascii u_min  (.bin({1'b0,  snap_min}),  .tens(min_t),  .ones(min_o));
  clock_bin2ascii u_sec  (.bin({1'b0,  snap_sec}),  .tens(sec_t),  .ones(sec_o));
  clock_bin2ascii u_msec (.bin(snap_msec),          .tens(msec_t), .ones(msec_o));

  // Select the frame byte at the current index; positions 8/9 depend on
  // whether the centiseconds field is present.
  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      4'd0:    cur_byte = hour_t;
      4'd1:    cur_byte = hour_o;
      4'd2:    cur_byte = ASCII_COLON;
      4'd3:    cur_byte = min_t;
      4'd4:    cur_byte = min_o;
      4'd5:    cur_byte = ASCII_COLON;
      4'd6:    cur_byte = sec_t;
      4'd7:    cur_byte = sec_o;
      4'd8:    cur_byte = (SEND_MSEC != 0) ? ASCII_DOT : ASCII_CR;
      4'd9:    cur_byte = (SEND_MSEC != 0) ? msec_t    : ASCII_LF;
      4'd10:   cur_byte = msec_o;
      4'd11:   cur_byte = ASCII_CR;
      4'd12:   cur_byte = ASCII_LF;
      default: cur_byte = 8'h00;
    endcase
  end

  // Frame sequencer: snapshot on request, then one strobe per byte, each
  // gated by the transmitter's busy rise and fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_msec <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            snap_hour <= hour;
            snap_min  <= min;
            snap_sec  <= sec;
            snap_msec <= msec;
            idx       <= '0;
            o_busy    <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SEND;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/clock_time_reporter.md
CLOCK_TIME_REPORTER -- requirements
Module: clock_time_reporter

Interface
REQ-001 Parameter: SEND_MSEC, default 1, meaning 1 = frame includes ".CC" centiseconds field, 0 = frame omits it.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 i_req  input  1  single-cycle request to report the current time.
REQ-005 hour  input  5  current hour, binary.
REQ-006 min  input  6  current minute, binary.
REQ-007 sec  input  6  current second, binary.
REQ-008 msec  input  7  current centisecond, binary.
REQ-009 tx_busy  input  1  UART transmitter busy flag.
REQ-010 tx_start  output  1  single-cycle byte-send strobe to the UART transmitter.
REQ-011 tx_data  output  8  ASCII byte, valid while tx_start=1.
REQ-012 o_busy  output  1  high from request acceptance until the frame completes.
REQ-013 o_done  output  1  single-cycle pulse after the last byte's transmission completes.

Function
REQ-014 Frame SHALL be "HH:MM:SS.CC" CR LF, 13 bytes, when SEND_MSEC=1, and "HH:MM:SS" CR LF, 10 bytes, when SEND_MSEC=0.
- Each field: two decimal ASCII digits, leading zero.
- Separators: ':'=0x3A, '.'=0x2E, CR=0x0D, LF=0x0A.
REQ-015 Field values above 99 SHALL be sent as "99" (saturate); no range check below 99.
REQ-016 In IDLE, i_req=1 at a rising edge SHALL snapshot hour/min/sec/msec into internal registers and set o_busy=1 on that edge.
REQ-017 Snapshot SHALL be the only sample taken; later input changes SHALL NOT affect the frame in progress.
REQ-018 i_req while o_busy=1 SHALL be ignored; no queuing.
REQ-019 FSM states and transitions:
- IDLE: wait for i_req.
- SEND: when tx_busy=0, drive tx_start=1 with tx_data=byte[idx] for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on tx_busy=0, if idx=last go to IDLE with o_done=1 for one cycle and o_busy=0, else idx+1 and go to SEND.
REQ-020 tx_start and tx_data SHALL be registered outputs.
REQ-021 With tx_busy=0 at request time, the first tx_start SHALL assert exactly 2 cycles after the edge that sampled i_req.
REQ-022 tx_start SHALL never assert while tx_busy=1, and SHALL never assert twice for one byte.
REQ-023 Byte index SHALL be wide enough for 13 and SHALL reset to 0 at each accepted request.
REQ-024 tx_data SHALL hold the last sent byte between strobes; it is 0x00 after reset.

Reset
REQ-025 rst=0 SHALL immediately force these values, abandoning any frame in progress:
- State = IDLE, idx = 0, snapshot = 0.
- tx_start = 0, tx_data = 0x00, o_busy = 0, o_done = 0.
REQ-026 After rst returns to 1, the block SHALL accept i_req from the first rising edge.

Structure
REQ-027 Shared package clock_report_pkg SHALL hold:
- ASCII constants (':', '.', CR, LF, '0').
- Frame lengths 13 and 10.
- FSM state encoding.
REQ-028 Sub-module clock_bin2ascii: combinational, binary 0-127 in, saturated two ASCII digits out; instantiated once per field (four instances).

Verification
REQ-029 After reset, inputs 12/0/0/0, i_req pulse, TX model busy 10 cycles per byte -> bytes 31 32 3A 30 30 3A 30 30 2E 30 30 0D 0A, then one o_done pulse.
REQ-030 Inputs 23/59/59/99, i_req, then inputs change to 0/0/0/0 during byte 3 -> frame still reads "23:59:59.99" CR LF.
REQ-031 Second i_req 5 cycles after the first -> exactly 13 tx_start pulses total and one o_done.
REQ-032 msec=127, hour=7, SEND_MSEC=0 build -> msec ignored, frame "07:..", 10 bytes; SEND_MSEC=1 build -> ".99".
REQ-033 tx_busy held high 50 cycles before the request -> first tx_start only after tx_busy falls; no strobe while busy.
REQ-034 rst=0 asserted during byte 6 -> all outputs 0 at once; new i_req after release -> complete 13-byte frame from byte 0.
